dsr_share_arbiter: RTL and testbench
====================================

# dsr_share_arbiter

Sequencer and two-port arbiter sharing one combinational 32-bit double-shift-right unit between the execute-stage shift/extract path (port 0) and the memory-alignment path (port 1). Captures each granted operand set, drives the shared shifter and registers the result in a one-entry output buffer with valid/ready backpressure. Sits beside the shifter in the execute stage; the shifter is instantiated outside this block and wired to the `dsr_*` ports.

## Interface
- `WIDTH`, 32, operand and result width (bits numbered 0 = MSB).
- `SA_W`, 5, shift-amount width.
- `TAG_W`, 4, requester-supplied tag returned with the result.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0_valid` / `req1_valid`  in  1  requester has an operation.
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  high / low words.
- `req0_sa` / `req1_sa`  in  SA_W  right shift amount.
- `req0_tag` / `req1_tag`  in  TAG_W  opaque tag.
- `dsr_a`, `dsr_b`  out  WIDTH  operands to shared shifter.
- `dsr_sa`  out  SA_W  shift amount to shared shifter.
- `dsr_y`  in  WIDTH  shifter result (combinational from `dsr_*`).
- `res_valid`  out  1  result buffer full.
- `res_ready`  in  1  consumer takes result.
- `res_y`  out  WIDTH  registered result.
- `res_src`  out  1  port that issued the result.
- `res_tag`  out  TAG_W  tag of that operation.

## Operation
- Shifter function: `dsr_y` = low WIDTH bits of ({a,b} >> sa); sa = 0 returns b.
- Buffer states: EMPTY (`res_valid`=0), FULL (`res_valid`=1).
- `can_accept` = EMPTY, or FULL and `res_ready`=1.
- Grant: if `can_accept` and at least one valid, exactly one port granted; `reqN_ready`=1 for the granted port only. Ready is combinational on valid and `res_ready`.
- Both valid: port at current priority pointer wins. After each grant, pointer moves to the other port; no grant leaves pointer unchanged.
- `dsr_a/b/sa` mux the granted port; when no grant, they mux the pointer port (value don't-care to consumers, never X after reset).
- On grant edge: `res_y`←`dsr_y`, `res_src`←port, `res_tag`←tag, state→FULL.
- FULL with `res_ready`=1 and no grant: state→EMPTY, data retained but invalid.
- FULL with `res_ready`=1 and grant: drain and refill same edge, stays FULL (back-to-back throughput 1/cycle).
- FULL with `res_ready`=0: no grant, all outputs held stable.
- Requester holding valid without ready keeps operands stable; block never drops a granted op.

## Timing
- Reset values: `res_valid`=0, `res_y`=0, `res_src`=0, `res_tag`=0, pointer=0 (port 0 priority); `reqN_ready`=0 while `rst_n`=0.
- Latency: op accepted at edge N appears on `res_*` after edge N (1 cycle).
- Throughput: one op/cycle with `res_ready` held high.
- Reset asserted mid-operation clears buffer and pointer immediately; in-flight result lost, no partial output after release.
- First edge after `rst_n` deassertion may grant.

## Configuration
- `DSR_ARB_ROUND_ROBIN_EN` defined: round-robin pointer as described.
- Not defined: fixed priority, port 0 always wins when both valid; pointer register removed, `dsr_*` default mux selects port 0.

## Test plan
- Single op: port 0 a=0x0000FF0F, b=0x00000FFF, sa=5 -> `req0_ready`=1 that cycle, next cycle `res_valid`=1, `res_y`=0x7800007F, `res_src`=0.
- Edge shifts: port 1 same operands sa=0 -> `res_y`=0x00000FFF; sa=31 -> `res_y`=0x0001FE1E, `res_src`=1.
- Contention: both valid continuously 4 cycles, `res_ready`=1, tags 0x1/0x2 -> grants alternate 0,1,0,1 (round-robin) or 0,0,0,0 (macro off).
- Backpressure: `res_ready`=0 for 3 cycles while FULL -> `reqN_ready`=0, `res_*` unchanged; raise `res_ready` -> drain and refill same edge, `res_valid` stays 1.
- Reset mid-flight: assert `rst_n`=0 asynchronously while FULL -> `res_valid`=0 immediately, pointer=0; after release, port 0 wins first contention.
- Idle drain: FULL, `res_ready`=1, no valids -> `res_valid`=0 next cycle, `res_y` retained.

Source files
------------

// File: rtl/dsr_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// dsr_share_arbiter_if
// Handshake bundle between the two shift requesters, the result consumer and
// dsr_share_arbiter.
//   req0_* : execute-stage shift/extract requester (valid/ready, a, b, sa, tag)
//   req1_* : memory-alignment requester (valid/ready, a, b, sa, tag)
//   res_*  : one-entry result buffer (valid/ready, y, src, tag)
// Modports:
//   slave  : arbiter side (takes requests, presents results)
//   master : requester/consumer side
// Data words are numbered with bit 0 as the MSB.
// ---------------------------------------------------------------------------
interface dsr_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5,
    parameter int TAG_W = 4
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [0:WIDTH-1]     req0_a;
    logic [0:WIDTH-1]     req0_b;
    logic [SA_W-1:0]      req0_sa;
    logic [TAG_W-1:0]     req0_tag;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [0:WIDTH-1]     req1_a;
    logic [0:WIDTH-1]     req1_b;
    logic [SA_W-1:0]      req1_sa;
    logic [TAG_W-1:0]     req1_tag;

    logic                 res_valid;
    logic                 res_ready;
    logic [0:WIDTH-1]     res_y;
    logic                 res_src;
    logic [TAG_W-1:0]     res_tag;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sa, req0_tag,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sa, req1_tag,
        output req1_ready,
        output res_valid, res_y, res_src, res_tag,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sa, req0_tag,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sa, req1_tag,
        input  req1_ready,
        input  res_valid, res_y, res_src, res_tag,
        output res_ready
    );
endinterface

// File: rtl/dsr_share_arbiter.sv
// ---------------------------------------------------------------------------
// dsr_share_arbiter
// Shares one external combinational double-shift-right unit between two
// requesters and registers the result in a one-entry valid/ready buffer.
//
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   bus (slave)     : req0_*/req1_* request handshakes, res_* result buffer
//   dsr_a/b/sa      : operands driven to the shared shifter
//   dsr_y           : shifter result, combinational from dsr_*
//
// Build option:
//   DSR_ARB_ROUND_ROBIN_EN  defined   -> alternating priority pointer
//                           undefined -> fixed priority, port 0 wins
//
// State | meaning
// ------+---------------------------------------------
// EMPTY | result buffer holds nothing valid
// FULL  | result buffer holds a result awaiting res_ready
// ---------------------------------------------------------------------------
module dsr_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dsr_share_arbiter_if.slave    bus,
    output logic [0:WIDTH-1]      dsr_a,
    output logic [0:WIDTH-1]      dsr_b,
    output logic [SA_W-1:0]       dsr_sa,
    input  logic [0:WIDTH-1]      dsr_y
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]           state;
    logic                 can_accept;
    logic                 grant0;
    logic                 grant1;
    logic                 any_grant;
    logic                 sel;
    logic                 ptr;
    logic [0:WIDTH-1]     res_y_q;
    logic                 res_src_q;
    logic [TAG_W-1:0]     res_tag_q;

`ifdef DSR_ARB_ROUND_ROBIN_EN
    // Pointer names the port that wins the next tie; it flips to the other
    // port after every grant, whichever port was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (any_grant) begin
            ptr <= grant0;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    // Ready is gated by rst_n so no handshake can complete while in reset.
    always_comb begin
        can_accept = (state == ST_EMPTY) || bus.res_ready;
        grant0     = rst_n && can_accept && bus.req0_valid
                     && (!bus.req1_valid || !ptr);
        grant1     = rst_n && can_accept && bus.req1_valid
                     && (!bus.req0_valid || ptr);
        any_grant  = grant0 || grant1;
        // Idle cycles park the mux on the pointer port so dsr_* stays defined.
        sel        = grant1 || (!grant0 && ptr);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign dsr_a  = sel ? bus.req1_a  : bus.req0_a;
    assign dsr_b  = sel ? bus.req1_b  : bus.req0_b;
    assign dsr_sa = sel ? bus.req1_sa : bus.req0_sa;

    // A grant while FULL with res_ready high drains and refills on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            res_y_q   <= '0;
            res_src_q <= 1'b0;
            res_tag_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (any_grant) state <= ST_FULL;
                ST_FULL:  if (!any_grant && bus.res_ready) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
            if (any_grant) begin
                res_y_q   <= dsr_y;
                res_src_q <= sel;
                res_tag_q <= sel ? bus.req1_tag : bus.req0_tag;
            end
        end
    end

    assign bus.res_valid = (state == ST_FULL);
    assign bus.res_y     = res_y_q;
    assign bus.res_src   = res_src_q;
    assign bus.res_tag   = res_tag_q;
endmodule

// File: tb/tb_dsr_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dsr_share_arbiter
// Self-checking bench for dsr_share_arbiter: directed scenarios followed by
// randomized traffic, with a scoreboard queue of expected results that a
// separate monitor pops on each result handshake.
// ---------------------------------------------------------------------------
module tb_dsr_share_arbiter;
    localparam int W  = 32;
    localparam int SW = 5;
    localparam int TW = 4;

    typedef struct {
        logic [31:0] y;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [0:W-1]  dsr_a;
    logic [0:W-1]  dsr_b;
    logic [SW-1:0] dsr_sa;
    logic [0:W-1]  dsr_y;
    logic [63:0]   dsr_cat;

    dsr_share_arbiter_if #(.WIDTH(W), .SA_W(SW), .TAG_W(TW)) bus ();

    dsr_share_arbiter #(.WIDTH(W), .SA_W(SW), .TAG_W(TW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .dsr_a  (dsr_a),
        .dsr_b  (dsr_b),
        .dsr_sa (dsr_sa),
        .dsr_y  (dsr_y)
    );

    // External shared shifter
    assign dsr_cat = {dsr_a, dsr_b} >> dsr_sa;
    assign dsr_y   = dsr_cat[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Reference model state
    logic        m_full;
    logic        m_ptr;
    logic [31:0] m_y;
    logic        m_src;
    logic [3:0]  m_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_dsr(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sa);
        logic [63:0] t;
        t = {a, b} >> sa;
        return t[31:0];
    endfunction

    function automatic int wins_tie();
`ifdef DSR_ARB_ROUND_ROBIN_EN
        return int'(m_ptr);
`else
        return 0;
`endif
    endfunction

    // One clock cycle: drive inputs after the edge, check against the model,
    // then advance the model to what the next edge should produce.
    task automatic do_cycle(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0,
        input logic [4:0] s0, input logic [3:0] t0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
        input logic [4:0] s1, input logic [3:0] t1,
        input logic rr, output logic g0, output logic g1);
        logic can;
        exp_t e;
        @(posedge clk);
        #1;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req0_sa = s0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.req1_sa = s1; bus.req1_tag = t1;
        bus.res_ready = rr;
        #1;
        can = !m_full || rr;
        g0  = can && v0 && (!v1 || wins_tie() == 0);
        g1  = can && v1 && (!v0 || wins_tie() == 1);
        chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
        chk("res_valid",  32'(bus.res_valid),  32'(m_full));
        chk("res_y",      bus.res_y,           m_y);
        chk("res_src",    32'(bus.res_src),    32'(m_src));
        chk("res_tag",    32'(bus.res_tag),    32'(m_tag));
        if (g0 || g1) begin
            e.src = g1;
            e.y   = g1 ? ref_dsr(a1, b1, s1) : ref_dsr(a0, b0, s0);
            e.tag = g1 ? t1 : t0;
            sb.push_back(e);
            m_y = e.y; m_src = e.src; m_tag = e.tag;
            m_full = 1'b1;
            m_ptr  = !e.src;
        end else if (rr) begin
            m_full = 1'b0;
        end
    endtask

    task automatic idle(input logic rr);
        logic g0, g1;
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rr, g0, g1);
    endtask

    task automatic model_reset();
        m_full = 0; m_ptr = 0; m_y = 0; m_src = 0; m_tag = 0;
        sb.delete();
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_y",     bus.res_y,          32'd0);
        chk("rst_res_tag",   32'(bus.res_tag),   32'd0);
        chk("rst_ready0",    32'(bus.req0_ready), 32'd0);
        model_reset();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.res_ready = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: a result leaves the buffer at the edge after a valid&&ready sample.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_y",   bus.res_y,            e.y);
                chk("sb_src", 32'(bus.res_src),     32'(e.src));
                chk("sb_tag", 32'(bus.res_tag),     32'(e.tag));
            end
        end
    end

    initial begin
        logic g0, g1;
        logic hv0, hv1, rr;
        logic [31:0] ha0, hb0, ha1, hb1;
        logic [4:0]  hs0, hs1;
        logic [3:0]  ht0, ht1;

        model_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sa = 0; bus.req0_tag = 0;
        bus.req1_valid = 1; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sa = 0; bus.req1_tag = 0;
        bus.res_ready = 1;
        #3;
        chk("reset_ready0", 32'(bus.req0_ready), 32'd0);
        chk("reset_ready1", 32'(bus.req1_ready), 32'd0);
        chk("reset_valid",  32'(bus.res_valid),  32'd0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        #9;
        rst_n = 1'b1;

        // Single op on port 0
        do_cycle(1, 32'h0000FF0F, 32'h00000FFF, 5, 4'h3, 0, 0, 0, 0, 0, 1, g0, g1);
        chk("single_grant", 32'(g0), 32'd1);
        idle(0);
        chk("single_y", bus.res_y, 32'h7800007F);
        // Idle drain: buffer empties, data retained
        idle(1);
        idle(0);
        chk("drain_valid", 32'(bus.res_valid), 32'd0);
        chk("drain_y",     bus.res_y,          32'h7800007F);

        // Edge shifts on port 1
        do_cycle(0, 0, 0, 0, 0, 1, 32'h0000FF0F, 32'h00000FFF, 0, 4'h5, 1, g0, g1);
        do_cycle(0, 0, 0, 0, 0, 1, 32'h0000FF0F, 32'h00000FFF, 31, 4'h6, 1, g0, g1);
        chk("sa0_y", bus.res_y, 32'h00000FFF);
        idle(1);
        chk("sa31_y",   bus.res_y,          32'h0001FE1E);
        chk("sa31_src", 32'(bus.res_src),   32'd1);

        // Contention, pointer back at port 0 here
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, 32'h1234, 32'h5678, 3, 4'h1, 1, 32'h9ABC, 32'hDEF0, 7, 4'h2, 1, g0, g1);
`ifdef DSR_ARB_ROUND_ROBIN_EN
            chk("contend_port", 32'(g1), 32'(i % 2));
`else
            chk("contend_port", 32'(g1), 32'd0);
`endif
        end

        // Backpressure: FULL, res_ready low three cycles, then drain+refill
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 32'hAAAA5555, 32'h0F0F0F0F, 9, 4'h7, 1, 32'h1, 32'h2, 1, 4'h8, 0, g0, g1);
            chk("bp_no_grant", 32'(g0 || g1), 32'd0);
        end
        do_cycle(1, 32'hAAAA5555, 32'h0F0F0F0F, 9, 4'h7, 1, 32'h1, 32'h2, 1, 4'h8, 1, g0, g1);
        idle(0);
        chk("bp_refill_valid", 32'(bus.res_valid), 32'd1);

        // Reset while FULL, then port 0 wins first contention
        reset_mid_cycle();
        do_cycle(1, 32'h11, 32'h22, 1, 4'h1, 1, 32'h33, 32'h44, 2, 4'h2, 1, g0, g1);
        chk("post_reset_port0", 32'(g0), 32'd1);
        idle(1);

        // Randomized traffic; a pending request keeps its operands stable
        hv0 = 0; hv1 = 0; g0 = 0; g1 = 0;
        ha0 = 0; hb0 = 0; hs0 = 0; ht0 = 0; ha1 = 0; hb1 = 0; hs1 = 0; ht1 = 0;
        for (int n = 0; n < 500; n++) begin
            if (!(hv0 && !g0)) begin
                hv0 = ($urandom_range(3) != 0);
                ha0 = $urandom; hb0 = $urandom;
                hs0 = 5'($urandom_range(31)); ht0 = 4'($urandom_range(15));
            end
            if (!(hv1 && !g1)) begin
                hv1 = ($urandom_range(3) != 0);
                ha1 = $urandom; hb1 = $urandom;
                hs1 = 5'($urandom_range(31)); ht1 = 4'($urandom_range(15));
            end
            rr = ($urandom_range(3) != 0);
            do_cycle(hv0, ha0, hb0, hs0, ht0, hv1, ha1, hb1, hs1, ht1, rr, g0, g1);
            if (n == 250) reset_mid_cycle();
            if (n == 250) begin
                hv0 = 0; hv1 = 0; g0 = 0; g1 = 0;
            end
        end

        idle(1);
        idle(1);
        idle(0);
        chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
